// File: rtl/qa_drv_hc_fifo_from_host_pkg.sv
// ============================================================================
// Module : qa_drv_hc_fifo_from_host_pkg
// Brief  : Shared host-channel types for the host-to-FPGA ring reader.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package qa_drv_hc_fifo_from_host_pkg;

    localparam int N_IDX_BITS       = 13;
    localparam int N_SLOT_BITS      = 3;
    localparam int CCI_CLDATA_WIDTH = 512;
    localparam int CCI_MDATA_WIDTH  = 16;
    localparam int CCI_CLADDR_WIDTH = 32;

    typedef logic [N_IDX_BITS-1:0]       t_FIFO_FROM_HOST_IDX;
    typedef logic [N_SLOT_BITS-1:0]      t_FROM_HOST_SLOT;
    typedef logic [CCI_CLDATA_WIDTH-1:0] t_cci_cldata;
    typedef logic [CCI_MDATA_WIDTH-1:0]  t_cci_mdata;
    typedef logic [CCI_CLADDR_WIDTH-1:0] t_cci_claddr;

    // Upper mdata bits identify this client; the low N_SLOT_BITS carry the slot.
    localparam t_cci_mdata MDATA_FROM_HOST_TAG = 16'h4000;

    typedef enum logic [3:0] {
        eREQ_WRLINE_I = 4'h1,
        eREQ_RDLINE_S = 4'h4
    } t_cci_req;

    typedef struct packed {
        t_cci_req    req_type;
        t_cci_claddr address;
        t_cci_mdata  mdata;
    } t_cci_ReqMemHdr;

    typedef struct packed {
        t_cci_mdata mdata;
    } t_cci_RspMemHdr;

    typedef struct packed {
        logic           rdValid;
        t_cci_RspMemHdr hdr;
        t_cci_cldata    data;
    } t_if_cci_c0_Rx;

    typedef struct packed {
        logic        afu_en;
        t_cci_claddr afu_read_frame;
    } t_CSR_AFU_STATE;

    typedef struct packed {
        logic           request;
        t_cci_ReqMemHdr readHeader;
    } t_FRAME_ARB_READ;

    typedef struct packed {
        logic request;
    } t_FRAME_ARB_WRITE;

    typedef struct packed {
        t_FRAME_ARB_READ  read;
        t_FRAME_ARB_WRITE write;
    } t_FRAME_ARB;

    typedef struct packed {
        logic readerGrant;
    } t_CHANNEL_GRANT_ARB;

    typedef struct packed {
        t_FIFO_FROM_HOST_IDX newestWriteIdx;
    } t_TO_FIFO_FROM_HOST;

    typedef struct packed {
        t_FIFO_FROM_HOST_IDX oldestReadIdx;
    } t_FROM_FIFO_FROM_HOST;

    function automatic logic is_from_host_tag(input t_cci_mdata m);
        return m[CCI_MDATA_WIDTH-1:N_SLOT_BITS] ==
               MDATA_FROM_HOST_TAG[CCI_MDATA_WIDTH-1:N_SLOT_BITS];
    endfunction

endpackage

`default_nettype wire

// File: rtl/qa_drv_hc_fifo_from_host_if.sv
// ============================================================================
// Module : qa_drv_hc_fifo_from_host_if
// Brief  : LEAP-facing receive port (head line, valid, consume).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface qa_drv_hc_fifo_from_host_if;
    import qa_drv_hc_fifo_from_host_pkg::*;

    t_cci_cldata rx_data;
    logic        rx_rdy;
    logic        rx_enable;

    modport master (output rx_data, output rx_rdy, input  rx_enable);
    modport slave  (input  rx_data, input  rx_rdy, output rx_enable);
endinterface

`default_nettype wire

// File: rtl/qa_drv_hc_fifo_from_host_rob.sv
// ============================================================================
// Module : qa_drv_hc_fifo_from_host_rob
// Brief  : Reorder buffer; slots allocated in order, filled in any order,
//          released in order from the head.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module qa_drv_hc_fifo_from_host_rob #(
    parameter int SLOT_BITS  = 3,
    parameter int DATA_WIDTH = 512
) (
    input  wire logic                  clk,
    input  wire logic                  reset_n,
    input  wire logic                  i_alloc,
    output logic [SLOT_BITS-1:0]       o_alloc_slot,
    output logic                       o_not_full,
    input  wire logic                  i_fill,
    input  wire logic [SLOT_BITS-1:0]  i_fill_slot,
    input  wire logic [DATA_WIDTH-1:0] i_fill_data,
    input  wire logic                  i_deq,
    output logic                       o_head_valid,
    output logic [DATA_WIDTH-1:0]      o_head_data
);
    localparam int N_SLOTS = 1 << SLOT_BITS;

    logic [SLOT_BITS-1:0]  r_tail;
    logic [SLOT_BITS-1:0]  r_head;
    logic [N_SLOTS-1:0]    r_pending;
    logic [N_SLOTS-1:0]    r_valid;
    logic [DATA_WIDTH-1:0] r_data [N_SLOTS];
    logic                  w_fill_ok;

    // Fills to slots that were never requested (e.g. stale after reset) are dropped.
    assign w_fill_ok = i_fill && r_pending[i_fill_slot];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_tail    <= '0;
            r_head    <= '0;
            r_pending <= '0;
            r_valid   <= '0;
        end else begin
            if (i_alloc) begin
                r_pending[r_tail] <= 1'b1;
                r_tail            <= r_tail + SLOT_BITS'(1);
            end
            if (w_fill_ok) begin
                r_pending[i_fill_slot] <= 1'b0;
                r_valid[i_fill_slot]   <= 1'b1;
            end
            if (i_deq) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + SLOT_BITS'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_fill_ok) begin
            r_data[i_fill_slot] <= i_fill_data;
        end
    end

    // Slots are used in ring order, so the tail being busy means every slot is.
    assign o_alloc_slot = r_tail;
    assign o_not_full   = !(r_pending[r_tail] || r_valid[r_tail]);
    assign o_head_valid = r_valid[r_head];
    assign o_head_data  = r_data[r_head];

endmodule

`default_nettype wire

// File: rtl/qa_drv_hc_fifo_from_host.sv
// ============================================================================
// Module : qa_drv_hc_fifo_from_host
// Brief  : Host-to-FPGA ring reader: issues CCI line reads, reorders the
//          responses and delivers lines in ring order. Optional macro
//          QA_HC_FROM_HOST_PTR_BATCH_EN batches consumer-index publishing.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module qa_drv_hc_fifo_from_host
    import qa_drv_hc_fifo_from_host_pkg::*;
(
    input  wire logic                  clk,
    input  wire logic                  reset_n,
    input  wire t_if_cci_c0_Rx         rx0,
    input  wire t_CSR_AFU_STATE        csr,
    output t_FRAME_ARB                 frame_reader,
    input  wire t_CHANNEL_GRANT_ARB    read_grant,
    input  wire t_TO_FIFO_FROM_HOST    status_to_fifo_from_host,
    output t_FROM_FIFO_FROM_HOST       fifo_from_host_to_status,
    qa_drv_hc_fifo_from_host_if.master rx
);

    t_FIFO_FROM_HOST_IDX r_req_idx;
    t_FIFO_FROM_HOST_IDX r_cons_idx;
    t_FIFO_FROM_HOST_IDX r_oldest;
    t_FROM_HOST_SLOT     w_tail;
    logic                w_not_full;
    logic                w_request;
    logic                w_alloc;
    logic                w_fill;
    logic                w_deq;
    logic                w_head_valid;
    t_cci_cldata         w_head_data;

    assign w_request = csr.afu_en &&
                       (r_req_idx != status_to_fifo_from_host.newestWriteIdx) &&
                       w_not_full;
    assign w_alloc   = w_request && read_grant.readerGrant;
    assign w_fill    = rx0.rdValid && is_from_host_tag(rx0.hdr.mdata);
    assign w_deq     = rx.rx_enable && w_head_valid;

    always_comb begin
        frame_reader                             = '0;
        frame_reader.read.request                = w_request;
        frame_reader.read.readHeader.req_type    = eREQ_RDLINE_S;
        frame_reader.read.readHeader.address     = csr.afu_read_frame + t_cci_claddr'(r_req_idx);
        frame_reader.read.readHeader.mdata       = MDATA_FROM_HOST_TAG | t_cci_mdata'(w_tail);
        frame_reader.write.request               = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_req_idx  <= '0;
            r_cons_idx <= '0;
        end else begin
            if (w_alloc) begin
                r_req_idx <= r_req_idx + t_FIFO_FROM_HOST_IDX'(1);
            end
            if (w_deq) begin
                r_cons_idx <= r_cons_idx + t_FIFO_FROM_HOST_IDX'(1);
            end
        end
    end

    qa_drv_hc_fifo_from_host_rob #(
        .SLOT_BITS  (N_SLOT_BITS),
        .DATA_WIDTH (CCI_CLDATA_WIDTH)
    ) u_rob (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_alloc      (w_alloc),
        .o_alloc_slot (w_tail),
        .o_not_full   (w_not_full),
        .i_fill       (w_fill),
        .i_fill_slot  (rx0.hdr.mdata[N_SLOT_BITS-1:0]),
        .i_fill_data  (rx0.data),
        .i_deq        (w_deq),
        .o_head_valid (w_head_valid),
        .o_head_data  (w_head_data)
    );

`ifdef QA_HC_FROM_HOST_PTR_BATCH_EN
    localparam int IDLE_LIMIT = 16;

    logic [3:0] r_idle_cnt;
    logic       w_quarter;
    logic       w_idle_pub;
    logic       w_publish;

    // Publish on each quarter-ring crossing, or once the consumer has gone quiet.
    assign w_quarter  = r_cons_idx[N_IDX_BITS-2] != r_oldest[N_IDX_BITS-2];
    assign w_idle_pub = !w_deq && (r_idle_cnt == 4'(IDLE_LIMIT-1)) && (r_cons_idx != r_oldest);
    assign w_publish  = w_quarter || w_idle_pub;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_oldest   <= '0;
            r_idle_cnt <= '0;
        end else if (w_publish) begin
            r_oldest   <= r_cons_idx;
            r_idle_cnt <= '0;
        end else if (w_deq) begin
            r_idle_cnt <= '0;
        end else if (r_idle_cnt != 4'(IDLE_LIMIT-1)) begin
            r_idle_cnt <= r_idle_cnt + 4'd1;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_oldest <= '0;
        end else begin
            r_oldest <= r_cons_idx;
        end
    end
`endif

    assign fifo_from_host_to_status.oldestReadIdx = r_oldest;
    assign rx.rx_rdy  = w_head_valid;
    assign rx.rx_data = w_head_data;

endmodule

`default_nettype wire

// File: tb/tb_qa_drv_hc_fifo_from_host.sv
// ============================================================================
// Module : tb_qa_drv_hc_fifo_from_host
// Brief  : Directed self-checking bench for the host-to-FPGA ring reader.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_qa_drv_hc_fifo_from_host;
    import qa_drv_hc_fifo_from_host_pkg::*;

`ifdef QA_HC_FROM_HOST_PTR_BATCH_EN
    localparam bit BATCH = 1'b1;
`else
    localparam bit BATCH = 1'b0;
`endif
    localparam logic [31:0] BASE = 32'h1000_0000;

    typedef struct {
        logic [15:0]  mdata;
        logic [511:0] data;
    } rsp_t;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    t_if_cci_c0_Rx        rx0 = '0;
    t_CSR_AFU_STATE       csr = '0;
    t_FRAME_ARB           frame_reader;
    t_CHANNEL_GRANT_ARB   read_grant;
    t_TO_FIFO_FROM_HOST   status_in = '0;
    t_FROM_FIFO_FROM_HOST status_out;

    logic gnt_en   = 1'b1;
    logic auto_rsp = 1'b0;
    logic auto_deq = 1'b0;
    logic man_deq  = 1'b0;
    logic sb_en    = 1'b0;
    logic cap_en   = 1'b0;

    rsp_t        resp_q [$];
    logic [31:0] log_addr [$];
    logic [15:0] log_mdata [$];
    int          sb_cnt = 0;
    int          auto_bad = 0;
    logic [12:0] first_pub = '0;
    int          n_checks = 0;
    int          n_errors = 0;

    qa_drv_hc_fifo_from_host_if rxif ();

    assign read_grant     = '{readerGrant: gnt_en & frame_reader.read.request};
    assign rxif.rx_enable = auto_deq ? rxif.rx_rdy : man_deq;

    qa_drv_hc_fifo_from_host dut (
        .clk                      (clk),
        .reset_n                  (reset_n),
        .rx0                      (rx0),
        .csr                      (csr),
        .frame_reader             (frame_reader),
        .read_grant               (read_grant),
        .status_to_fifo_from_host (status_in),
        .fifo_from_host_to_status (status_out),
        .rx                       (rxif.master)
    );

    always #5 clk = ~clk;

    // Mid-cycle: drive queued responses, log grants, run the streaming scoreboard.
    always @(negedge clk) begin
        rsp_t r;
        if (resp_q.size() > 0) begin
            r   = resp_q.pop_front();
            rx0 = '{rdValid: 1'b1, hdr: '{mdata: r.mdata}, data: r.data};
        end else begin
            rx0 = '0;
        end
        if (reset_n && read_grant.readerGrant) begin
            log_addr.push_back(frame_reader.read.readHeader.address);
            log_mdata.push_back(frame_reader.read.readHeader.mdata);
            if (auto_rsp) begin
                resp_q.push_back('{frame_reader.read.readHeader.mdata,
                                   512'(frame_reader.read.readHeader.address)});
            end
        end
        if (sb_en && rxif.rx_enable && rxif.rx_rdy) begin
            if (rxif.rx_data !== 512'(BASE + 32'(sb_cnt % 8192))) auto_bad++;
            sb_cnt++;
        end
        if (cap_en && first_pub == 13'd0 && status_out.oldestReadIdx != 13'd0) begin
            first_pub = status_out.oldestReadIdx;
        end
    end

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        cyc(2);
        reset_n = 1'b1;
        log_addr.delete();
        log_mdata.delete();
    endtask

    task automatic push_rsp(input int slot, input logic [511:0] data);
        resp_q.push_back('{16'h4000 | 16'(slot), data});
    endtask

    task automatic deq_check(input string tag, input logic [511:0] exp);
        int t = 0;
        while (!rxif.rx_rdy && t < 50) begin
            cyc(1);
            t++;
        end
        chk({tag, "_rdy"}, 512'(rxif.rx_rdy), 512'(1));
        chk(tag, rxif.rx_data, exp);
        man_deq = 1'b1;
        cyc(1);
        man_deq = 1'b0;
    endtask

    initial begin
        int t;

        // ---- reset state, then 4 in-order lines
        csr = '{afu_en: 1'b0, afu_read_frame: BASE};
        status_in.newestWriteIdx = 13'd4;
        do_reset();
        chk("reset_rdy", 512'(rxif.rx_rdy), 512'(0));
        chk("reset_req", 512'(frame_reader.read.request), 512'(0));
        chk("reset_oldest", 512'(status_out.oldestReadIdx), 512'(0));
        csr.afu_en = 1'b1;
        cyc(8);
        chk("t1_nreq", 512'(log_addr.size()), 512'(4));
        for (int i = 0; i < 4; i++) chk("t1_addr", 512'(log_addr[i]), 512'(BASE + 32'(i)));
        chk("t1_mdata0", 512'(log_mdata[0]), 512'(16'h4000));
        chk("t1_mdata3", 512'(log_mdata[3]), 512'(16'h4003));
        for (int i = 0; i < 4; i++) push_rsp(i, 512'(32'hA0 + i));
        for (int i = 0; i < 4; i++) deq_check("t1_data", 512'(32'hA0 + i));
        cyc(20);
        chk("t1_oldest", 512'(status_out.oldestReadIdx), 512'(4));
        chk("t1_req_empty", 512'(frame_reader.read.request), 512'(0));

        // ---- 8 lines, responses out of order
        status_in.newestWriteIdx = 13'd8;
        do_reset();
        cyc(12);
        chk("t2_nreq", 512'(log_addr.size()), 512'(8));
        push_rsp(3, 512'(32'hB3)); push_rsp(1, 512'(32'hB1));
        push_rsp(0, 512'(32'hB0)); push_rsp(2, 512'(32'hB2));
        push_rsp(7, 512'(32'hB7)); push_rsp(5, 512'(32'hB5));
        push_rsp(4, 512'(32'hB4)); push_rsp(6, 512'(32'hB6));
        cyc(1);
        chk("t2_rdy_s3", 512'(rxif.rx_rdy), 512'(0));
        cyc(1);
        chk("t2_rdy_s1", 512'(rxif.rx_rdy), 512'(0));
        cyc(1);
        chk("t2_rdy_s0", 512'(rxif.rx_rdy), 512'(1));
        for (int i = 0; i < 8; i++) deq_check("t2_data", 512'(32'hB0 + i));

        // ---- responses withheld: 8 outstanding, then one deq frees a slot
        status_in.newestWriteIdx = 13'd20;
        do_reset();
        cyc(15);
        chk("t3_nreq", 512'(log_addr.size()), 512'(8));
        chk("t3_req_full", 512'(frame_reader.read.request), 512'(0));
        push_rsp(0, 512'(32'hC0));
        cyc(2);
        chk("t3_req_valid_slot", 512'(frame_reader.read.request), 512'(0));
        deq_check("t3_data", 512'(32'hC0));
        chk("t3_req_freed", 512'(frame_reader.read.request), 512'(1));
        cyc(2);
        chk("t3_nreq9", 512'(log_addr.size()), 512'(9));
        chk("t3_addr8", 512'(log_addr[8]), 512'(BASE + 32'd8));
        chk("t3_mdata8", 512'(log_mdata[8]), 512'(16'h4000));

        // ---- reset with 3 outstanding reads; late responses must be dropped
        status_in.newestWriteIdx = 13'd3;
        do_reset();
        cyc(6);
        chk("t5_nreq", 512'(log_addr.size()), 512'(3));
        csr.afu_en = 1'b0;
        do_reset();
        for (int i = 0; i < 3; i++) push_rsp(i, 512'(32'hD0 + i));
        cyc(8);
        chk("t5_rdy", 512'(rxif.rx_rdy), 512'(0));
        chk("t5_oldest", 512'(status_out.oldestReadIdx), 512'(0));

        // ---- consume 10 lines then idle: publish timing of oldestReadIdx
        csr.afu_en = 1'b1;
        status_in.newestWriteIdx = 13'd10;
        auto_rsp = 1'b1;
        do_reset();
        cyc(20);
        for (int k = 1; k <= 10; k++) begin
            deq_check("t6_data", 512'(BASE + 32'(k - 1)));
            chk("t6_oldest_run", 512'(status_out.oldestReadIdx), 512'(BATCH ? 0 : k - 1));
        end
        cyc(14);
        chk("t6_oldest_15", 512'(status_out.oldestReadIdx), 512'(BATCH ? 0 : 10));
        cyc(1);
        chk("t6_oldest_16", 512'(status_out.oldestReadIdx), 512'(10));

        // ---- stream to 8190, then wrap through 8191, 0, 1
        status_in.newestWriteIdx = 13'd8190;
        sb_cnt = 0; auto_bad = 0; first_pub = '0;
        do_reset();
        sb_en = 1'b1; cap_en = 1'b1; auto_deq = 1'b1;
        t = 0;
        while (status_out.oldestReadIdx != 13'd8190 && t < 20000) begin
            cyc(1);
            t++;
        end
        chk("t4_oldest_8190", 512'(status_out.oldestReadIdx), 512'(8190));
        chk("t4_first_pub", 512'(first_pub), 512'(BATCH ? 2048 : 1));
        log_addr.delete();
        status_in.newestWriteIdx = 13'd2;
        cyc(40);
        chk("t4_nreq", 512'(log_addr.size()), 512'(4));
        chk("t4_addr0", 512'(log_addr[0]), 512'(BASE + 32'd8190));
        chk("t4_addr1", 512'(log_addr[1]), 512'(BASE + 32'd8191));
        chk("t4_addr2", 512'(log_addr[2]), 512'(BASE));
        chk("t4_addr3", 512'(log_addr[3]), 512'(BASE + 32'd1));
        chk("t4_req_idle", 512'(frame_reader.read.request), 512'(0));
        chk("t4_oldest_2", 512'(status_out.oldestReadIdx), 512'(2));
        chk("t4_ndeq", 512'(sb_cnt), 512'(8194));
        chk("t4_stream_data", 512'(auto_bad), 512'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
